// File: rtl/adder_pkg.sv
// Shared types and helpers for the carry-segmented pipelined adder.
package adder_pkg;

    typedef enum logic {
        ADD = 1'b0,
        SUB = 1'b1
    } adder_op_e;

    function automatic int seg_width(input int width, input int stages);
        return width / stages;
    endfunction

endpackage

// File: rtl/adder_seg_stage.sv
// One pipeline stage: resolves segment IDX of the word and registers its carry,
// the operand words for later stages and the partially built result.
module adder_seg_stage #(
    parameter int WIDTH = 32,
    parameter int SEG   = 8,
    parameter int IDX   = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             advance,
    input  logic             i_valid,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_be,
    input  logic [WIDTH-1:0] i_res,
    input  logic             i_c,
    output logic             o_valid,
    output logic [WIDTH-1:0] o_a,
    output logic [WIDTH-1:0] o_be,
    output logic [WIDTH-1:0] o_res,
    output logic             o_c
);

    logic [SEG:0]       w_seg_sum;
    logic [WIDTH-1:0]   w_res;

    logic               r_valid;
    logic               r_c;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_be;
    logic [WIDTH-1:0]   r_res;

    assign w_seg_sum = {1'b0, i_a[IDX*SEG +: SEG]}
                     + {1'b0, i_be[IDX*SEG +: SEG]}
                     + {{SEG{1'b0}}, i_c};

    // Lower segments arrive already resolved; only this stage's slice is replaced.
    always_comb begin
        w_res                   = i_res;
        w_res[IDX*SEG +: SEG]   = w_seg_sum[SEG-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_c     <= 1'b0;
            r_a     <= '0;
            r_be    <= '0;
            r_res   <= '0;
        end else if (advance) begin
            r_valid <= i_valid;
            r_c     <= w_seg_sum[SEG];
            r_a     <= i_a;
            r_be    <= i_be;
            r_res   <= w_res;
        end
    end

    assign o_valid = r_valid;
    assign o_c     = r_c;
    assign o_a     = r_a;
    assign o_be    = r_be;
    assign o_res   = r_res;

endmodule

// File: rtl/pipelined_adder_seg.sv
// Carry-segmented pipelined adder/subtractor with a global-stall valid/ready pipe.
// Operand conditioning, overflow flag and in_ready live here; stages do the math.
module pipelined_adder_seg
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int SEG = seg_width(WIDTH, STAGES);
    localparam int MSB = WIDTH - 1;

    generate
        if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
            $error("pipelined_adder_seg: WIDTH must be a non-zero multiple of STAGES");
        end
    endgenerate

    adder_op_e          w_op;
    logic               w_advance;
    logic [WIDTH-1:0]   w_be_in;
    logic               w_c0;

    logic               w_valid [0:STAGES];
    logic               w_c     [0:STAGES];
    logic [WIDTH-1:0]   w_a     [0:STAGES];
    logic [WIDTH-1:0]   w_be    [0:STAGES];
    logic [WIDTH-1:0]   w_res   [0:STAGES];
    logic               w_unused;

    assign w_op      = adder_op_e'(sub);
    assign w_be_in   = (w_op == SUB) ? ~b : b;
    assign w_c0      = (w_op == SUB) ? ~cin : cin;

    // Bubbles at the output never block, so the pipe only freezes on a real stall.
    assign w_advance = out_ready || !out_valid;
    assign in_ready  = w_advance;

    assign w_valid[0] = in_valid;
    assign w_c[0]     = w_c0;
    assign w_a[0]     = a;
    assign w_be[0]    = w_be_in;
    assign w_res[0]   = '0;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        adder_seg_stage #(
            .WIDTH (WIDTH),
            .SEG   (SEG),
            .IDX   (k)
        ) u_stage (
            .clk     (clk),
            .rst_n   (rst_n),
            .advance (w_advance),
            .i_valid (w_valid[k]),
            .i_a     (w_a[k]),
            .i_be    (w_be[k]),
            .i_res   (w_res[k]),
            .i_c     (w_c[k]),
            .o_valid (w_valid[k+1]),
            .o_a     (w_a[k+1]),
            .o_be    (w_be[k+1]),
            .o_res   (w_res[k+1]),
            .o_c     (w_c[k+1])
        );
    end

    assign out_valid = w_valid[STAGES];
    assign sum       = w_res[STAGES];
    assign cout      = w_c[STAGES];
    assign ovf       = (w_a[STAGES][MSB] == w_be[STAGES][MSB]) && (sum[MSB] != w_a[STAGES][MSB]);

    // Only the operand sign bits matter once the last segment is resolved.
    assign w_unused  = &{1'b0, w_a[STAGES][MSB:0], w_be[STAGES][MSB:0]};

endmodule

// File: tb/tb_pipelined_adder_seg.sv
// Scoreboard bench: default 32/4 instance with directed and random traffic,
// plus 64/8, 16/1 and 8/8 instances streaming random beats under backpressure.
module tb_pipelined_adder_seg;
    import adder_pkg::*;

    localparam int W = 32;
    localparam int S = 4;

    typedef struct {
        logic [63:0] sum;
        logic        cout;
        logic        ovf;
        int          acc;
        bit          lat;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    logic rst_n, rst_n_sw;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string nm, input string what);
        checks++;
        errors++;
        $display("FAIL %s: %s (cycle %0d)", nm, what, cyc);
    endtask

    // Reference: exact integer arithmetic on unsigned and signed interpretations.
    function automatic exp_t model(input int w, input logic [63:0] ta, input logic [63:0] tbv,
                                   input logic tc, input logic ts);
        exp_t e;
        logic signed [127:0] two_w, half, ua, ub, sa, sb, cn, ru, rs;
        logic [63:0] mask;
        mask  = (w >= 64) ? {64{1'b1}} : ((64'd1 << w) - 64'd1);
        two_w = 128'sd1 <<< w;
        half  = 128'sd1 <<< (w - 1);
        ua    = $signed({64'd0, ta & mask});
        ub    = $signed({64'd0, tbv & mask});
        sa    = ta[w-1]  ? ua - two_w : ua;
        sb    = tbv[w-1] ? ub - two_w : ub;
        cn    = $signed({127'd0, tc});
        ru    = ts ? (ua - ub - cn) : (ua + ub + cn);
        rs    = ts ? (sa - sb - cn) : (sa + sb + cn);
        e.sum  = ru[63:0] & mask;
        e.cout = ts ? (ru >= 0) : (ru >= two_w);
        e.ovf  = (rs >= half) || (rs < -half);
        e.acc  = 0;
        e.lat  = 1'b0;
        return e;
    endfunction

    // ---------------- default instance ----------------
    logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
    logic [W-1:0]  a, b, sum;
    exp_t          mq[$];
    bit            lat_on;
    bit            bp_done;

    pipelined_adder_seg #(.WIDTH(W), .STAGES(S)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc, input logic ts);
        exp_t e;
        int   n;
        bit   ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1; a = ta; b = tbv; cin = tc; sub = ts;
        while (!ok && n < 200) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            else n++;
        end
        if (ok) begin
            e     = model(W, 64'(ta), 64'(tbv), tc, ts);
            e.acc = cyc + 1;
            e.lat = lat_on;
            mq.push_back(e);
        end else begin
            fail_now("send_timeout", "in_ready never rose");
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain(input int lim);
        int n;
        n = 0;
        while (mq.size() != 0 && n < lim) begin
            @(posedge clk);
            n++;
        end
        if (mq.size() != 0) fail_now("drain_timeout", $sformatf("%0d results never emerged", mq.size()));
        @(posedge clk);
        #1;
    endtask

    logic         p_stall = 1'b0;
    logic [W-1:0] p_sum;
    logic         p_cout, p_ovf;

    initial begin : main_mon
        exp_t m;
        forever begin
            @(negedge clk);
            chk("in_ready_rule", 64'(in_ready), 64'(out_ready || !out_valid));
            if (!rst_n) begin
                p_stall = 1'b0;
            end else begin
                if (p_stall) begin
                    chk("stall_valid", 64'(out_valid), 64'd1);
                    chk("stall_sum",   64'(sum),  64'(p_sum));
                    chk("stall_cout",  64'(cout), 64'(p_cout));
                    chk("stall_ovf",   64'(ovf),  64'(p_ovf));
                end
                if (out_valid && out_ready) begin
                    if (mq.size() == 0) begin
                        fail_now("unexpected_out", $sformatf("got sum 0x%0h, required no output", sum));
                    end else begin
                        m = mq.pop_front();
                        chk("sum",  64'(sum),  m.sum);
                        chk("cout", 64'(cout), 64'(m.cout));
                        chk("ovf",  64'(ovf),  64'(m.ovf));
                        if (m.lat) chk("latency", 64'(cyc - m.acc), 64'(S - 1));
                    end
                end
                p_stall = out_valid && !out_ready;
                p_sum   = sum;
                p_cout  = cout;
                p_ovf   = ovf;
            end
        end
    end

    // ---------------- parameter sweep instances ----------------
    bit sw_done [3];

    for (genvar g = 0; g < 3; g++) begin : g_sw
        localparam int GW = (g == 0) ? 64 : ((g == 1) ? 16 : 8);
        localparam int GS = (g == 0) ? 8  : ((g == 1) ? 1  : 8);

        logic          gv, gr, gcin, gsub, gov, gor, gco, gof;
        logic [GW-1:0] ga, gb, gs;
        exp_t          q[$];

        pipelined_adder_seg #(.WIDTH(GW), .STAGES(GS)) u_dut (
            .clk       (clk),
            .rst_n     (rst_n_sw),
            .in_valid  (gv),
            .in_ready  (gr),
            .a         (ga),
            .b         (gb),
            .cin       (gcin),
            .sub       (gsub),
            .out_valid (gov),
            .out_ready (gor),
            .sum       (gs),
            .cout      (gco),
            .ovf       (gof)
        );

        initial begin : drv
            exp_t e;
            int   sent;
            bit   acc;
            sent = 0;
            gv = 1'b0; ga = '0; gb = '0; gcin = 1'b0; gsub = 1'b0; gor = 1'b1;
            sw_done[g] = 1'b0;
            wait (rst_n_sw);
            @(posedge clk);
            #1;
            for (int cy = 0; cy < 2000 && sent < 40; cy++) begin
                if (sent >= 25) gor = ($urandom_range(0, 2) != 0);
                if (!gv && $urandom_range(0, 3) != 0) begin
                    ga   = GW'({$urandom, $urandom});
                    gb   = GW'({$urandom, $urandom});
                    gcin = 1'($urandom_range(0, 1));
                    gsub = 1'($urandom_range(0, 1));
                    gv   = 1'b1;
                end
                @(negedge clk);
                acc = gv && gr;
                if (acc) begin
                    e     = model(GW, 64'(ga), 64'(gb), gcin, gsub);
                    e.acc = cyc + 1;
                    e.lat = (sent < 10);
                    q.push_back(e);
                    sent++;
                end
                @(posedge clk);
                #1;
                if (acc) gv = 1'b0;
            end
            gv  = 1'b0;
            gor = 1'b1;
            for (int cy = 0; cy < 200 && q.size() != 0; cy++) @(posedge clk);
            if (sent != 40) fail_now($sformatf("sw%0d_stream", g), $sformatf("sent %0d beats, required 40", sent));
            sw_done[g] = 1'b1;
        end

        initial begin : mon
            exp_t m;
            forever begin
                @(negedge clk);
                if (rst_n_sw) begin
                    chk($sformatf("sw%0d_in_ready_rule", g), 64'(gr), 64'(gor || !gov));
                    if (gov && gor) begin
                        if (q.size() == 0) begin
                            fail_now($sformatf("sw%0d_unexpected_out", g), $sformatf("got sum 0x%0h", gs));
                        end else begin
                            m = q.pop_front();
                            chk($sformatf("sw%0d_sum", g),  64'(gs),  m.sum);
                            chk($sformatf("sw%0d_cout", g), 64'(gco), 64'(m.cout));
                            chk($sformatf("sw%0d_ovf", g),  64'(gof), 64'(m.ovf));
                            if (m.lat) chk($sformatf("sw%0d_latency", g), 64'(cyc - m.acc), 64'(GS - 1));
                        end
                    end
                end
            end
        end
    end

    // ---------------- directed sequence ----------------
    initial begin : main_seq
        int n;
        rst_n = 1'b0; rst_n_sw = 1'b0;
        in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        lat_on = 1'b1; bp_done = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1; rst_n_sw = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 64'(out_valid), 64'd0);
        chk("reset_sum",       64'(sum),       64'd0);
        chk("reset_cout",      64'(cout),      64'd0);
        chk("reset_ovf",       64'(ovf),       64'd0);
        chk("reset_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk);
        #1;

        send(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, ADD);
        drain(50);

        send(32'd5,         32'd7,          1'b0, SUB);
        send(32'h8000_0000, 32'h0000_0001,  1'b0, SUB);
        send(32'h7FFF_FFFF, 32'h0000_0001,  1'b0, ADD);
        send(32'h0000_0000, 32'h0000_0000,  1'b1, SUB);
        send(32'hFFFF_FFFF, 32'hFFFF_FFFF,  1'b1, ADD);
        drain(50);

        for (int i = 0; i < 30; i++)
            send($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        drain(50);

        // Valid on cycles 0, 2, 3 only.
        send(32'h1111_0000, 32'h0000_2222, 1'b0, ADD);
        @(posedge clk);
        #1;
        send(32'h0000_0010, 32'h0000_0020, 1'b0, SUB);
        send(32'h1234_5678, 32'h0FED_CBA9, 1'b1, ADD);
        drain(50);

        lat_on = 1'b0;
        fork
            begin
                while (!bp_done) begin
                    @(posedge clk);
                    #1;
                    if (!bp_done) out_ready = 1'($urandom_range(0, 1));
                end
            end
        join_none
        for (int i = 0; i < 10; i++) send(32'h0000_1000 + 32'(i), 32'(i), 1'b0, ADD);
        drain(500);
        bp_done = 1'b1;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        lat_on = 1'b1;
        @(posedge clk);
        #1;

        out_ready = 1'b0;
        send(32'hAAAA_0001, 32'h0000_0001, 1'b0, ADD);
        send(32'hAAAA_0002, 32'h0000_0002, 1'b0, ADD);
        send(32'hAAAA_0003, 32'h0000_0003, 1'b0, ADD);
        repeat (2) @(posedge clk);
        #3;
        chk("pre_reset_out_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_out_valid", 64'(out_valid), 64'd0);
        mq.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (12) @(posedge clk);
        #1;

        n = 0;
        while (!(sw_done[0] && sw_done[1] && sw_done[2]) && n < 5000) begin
            @(posedge clk);
            n++;
        end
        if (!(sw_done[0] && sw_done[1] && sw_done[2])) fail_now("sweep_timeout", "sweep streams did not finish");
        chk("main_queue_empty", 64'(mq.size()), 64'd0);
        chk("sw0_queue_empty",  64'(g_sw[0].q.size()), 64'd0);
        chk("sw1_queue_empty",  64'(g_sw[1].q.size()), 64'd0);
        chk("sw2_queue_empty",  64'(g_sw[2].q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pipelined_adder_seg.md
# pipelined_adder_seg

Parametrised, carry-segmented pipelined adder/subtractor with valid/ready flow control. `WIDTH`-bit operands are split into `STAGES` equal segments. Each pipeline stage resolves one segment and registers the carry into the next, so clock rate scales with segment width rather than full word width. It replaces the fixed 32-bit two-register adder in datapaths that need wider words, subtraction, status flags and backpressure.

## Interface
- `WIDTH`, 32: operand and result width; must be a multiple of `STAGES` (elaboration-time assertion).
- `STAGES`, 4: number of pipeline stages and carry segments, 1..WIDTH; segment width `SEG = WIDTH/STAGES`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: reset, asynchronous, active-low.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: block can accept a beat this cycle.
- `a` in WIDTH: operand A.
- `b` in WIDTH: operand B.
- `cin` in 1: carry-in (add) / borrow-in (sub).
- `sub` in 1: 0 = add, 1 = subtract.
- `out_valid` out 1: result beat valid.
- `out_ready` in 1: downstream accepts result.
- `sum` out WIDTH: result, modulo 2^WIDTH.
- `cout` out 1: carry-out of MSB; for subtract, 1 = no borrow.
- `ovf` out 1: signed two's-complement overflow.

## Operation
- Effective operands: `be = sub ? ~b : b`, `c0 = sub ? ~cin : cin`.
  - Add computes `a + b + cin`.
  - Subtract computes `a - b - cin`.
- Stage k (0..STAGES-1) adds segment k of `a` and `be` plus the registered carry from stage k-1 (`c0` for k = 0).
- Per stage, registered:
  - the segment result;
  - the carry out;
  - the unprocessed upper segments of `a`/`be`;
  - the already-resolved lower result segments (skew/deskew);
  - a valid bit.
- `cout`: carry out of the final segment.
- `ovf = (a[MSB] == be[MSB]) && (sum[MSB] != a[MSB])`. `a[MSB]` and `be[MSB]` are carried down the pipe.
- Flow control is a global stall: `advance = out_ready || !out_valid`; `in_ready = advance`.
  - On `advance` every stage register loads from its predecessor. Stage 0 loads `in_valid` and operands.
  - When not advancing, all stage registers hold.
- Bubbles (valid = 0) propagate like data. No compaction.
- `sum`/`cout`/`ovf` are the last stage's registers and are held stable while `out_valid && !out_ready`.
- Data registers of invalid beats may hold stale values. Only valid bits are required to be 0 after reset.

## Timing
- Reset: all valid bits, `out_valid`, `sum`, `cout`, `ovf` = 0. `in_ready` = 1 once reset is released, because `out_valid` = 0.
- Latency: a beat accepted at edge N (`in_valid && in_ready`) is presented with `out_valid = 1` after edge N+STAGES-1, i.e. visible in the cycle following that edge, when there is no stall.
- Throughput: one beat per cycle when `out_ready` is held high.
- Stall: `out_valid && !out_ready` forces `in_ready = 0` in the same cycle (combinational). Upstream must hold its beat.
- `in_ready` depends combinationally on `out_ready`. No other combinational input-to-output path exists.
- Simultaneous output handshake and input accept in one cycle is legal and required. The pipe shifts by one.
- Reset asserted mid-operation discards all in-flight beats immediately (asynchronous). No partial result appears.
- `STAGES = 1`: a single registered full-width add, latency 1.
- `STAGES = WIDTH`: ripple, one bit per stage.

## Structure
- Shared package `adder_pkg`:
  - `adder_op_e` (`ADD`, `SUB`) enumeration used for `sub` decoding in testbenches and callers;
  - a function `seg_width(WIDTH, STAGES)`.
- Sub-module `adder_seg_stage`, instantiated `STAGES` times via generate. It contains the SEG-bit adder, carry register, operand/result shift registers and valid bit, with a shared `advance` input.
- The top level holds operand pre-conditioning, flag logic and `in_ready`.
- Expected size: about 200 RTL lines.

## Test plan
- Reset/idle, default params: release `rst_n`, no input → `out_valid` = 0, `sum` = 0, `in_ready` = 1. Assert `rst_n` low with 3 beats in flight → `out_valid` drops immediately; nothing emerges after release.
- Carry across all segments: `a = 0xFFFFFFFF`, `b = 0x00000001`, `cin = 0`, add → after 4 cycles `sum = 0x00000000`, `cout = 1`, `ovf = 0`.
- Subtract and signed overflow, one beat per cycle, `out_ready = 1`:
  - `5 - 7` → `sum = 0xFFFFFFFE`, `cout = 0`.
  - `0x80000000 - 1` → `sum = 0x7FFFFFFF`, `ovf = 1`.
  - `0x7FFFFFFF + 1` → `sum = 0x80000000`, `ovf = 1`.
  - Results must appear on consecutive cycles in order.
- Backpressure: stream 10 increasing beats and toggle `out_ready` pseudo-randomly → every result is output exactly once, in order, and values are stable during stalls. `in_ready` equals `out_ready || !out_valid` every cycle.
- Parameter sweep with random operands and a scoreboard against `a ± b ± cin`:
  - (`WIDTH = 64`, `STAGES = 8`): latency 8;
  - (`WIDTH = 16`, `STAGES = 1`): latency 1;
  - (`WIDTH = 8`, `STAGES = 8`).
- Bubble handling: inputs `valid` on cycles 0, 2, 3 only → outputs valid on exactly the corresponding cycles offset by `STAGES`, with correct data.
